itype_alu_encoder: RTL and testbench
====================================

# itype_alu_encoder

Streaming encoder for RV32I I-type ALU instructions (addi, slti, sltiu, xori, ori, andi, slli, srli, srai).

- Takes decoded fields (func3, rd, rs1, immediate, arithmetic-shift flag) and packs them into 32-bit words with opcode 0010011.
- Assigns each word a sequential instruction-memory address.
- Delivers words through a 2-entry output FIFO with valid/ready handshakes.
- Sits in the test/boot path and feeds the instruction memory the core fetches from. It generates the bit patterns the control-unit I-type decoders consume.

## Interface

Parameters:
- ADDR_W, 32: width of the address counter and out_addr.
- BASE_ADDR, 0: address loaded into the counter on start.

Ports:
- clk  in  1  processor clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle pulse; begins a session.
- last  in  1  qualifies the current input beat as the final one of the session.
- in_valid  in  1  input beat valid.
- in_ready  out  1  encoder accepts a beat this cycle.
- in_func3  in  3  func3 field.
- in_arith  in  1  selects srai over srli when in_func3=101; ignored otherwise.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register.
- in_imm  in  12  immediate, or shamt in [4:0] for shifts.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_insn  out  32  encoded instruction at the FIFO head.
- out_addr  out  ADDR_W  address of out_insn.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at the end of a session.
- err  out  1  one-cycle pulse when an illegal beat is dropped.

## Operation

Encoding: out_insn = {imm12, rs1, func3, rd, 7'b0010011}. imm12 is formed as follows:
- func3 = 000, 010, 011, 100, 110, 111: imm12 = in_imm.
- func3 = 001 (slli): imm12 = {7'b0000000, in_imm[4:0]}.
- func3 = 101 (srli/srai): imm12 = {in_arith ? 7'b0100000 : 7'b0000000, in_imm[4:0]}. Bit 30 of the instruction equals in_arith.

States and transitions:
- IDLE: in_ready = 0. On start, load the address counter with BASE_ADDR and go to RUN.
- RUN: in_ready = !fifo_full.
  - An accepted beat (in_valid & in_ready) is encoded and pushed with the current counter value, then the counter advances by 4.
  - The counter wraps modulo 2^ADDR_W.
  - An accepted beat with last = 1 moves the FSM to DRAIN.
- DRAIN: in_ready = 0. When the FIFO is empty, pulse done for one cycle and return to IDLE.
- start outside IDLE is ignored.

FIFO:
- Depth 2. out_valid = !fifo_empty; head pops on out_valid & out_ready.
- Push and pop in the same cycle: legal at any occupancy permitted by in_ready; occupancy stays unchanged.
- in_ready depends only on state and registered occupancy. There is no combinational path from out_ready to in_ready, so a full FIFO refuses input even while popping.

Reset, when reset_n = 0 at a rising edge, takes priority over every other event:
- state = IDLE, FIFO emptied, counter = BASE_ADDR.
- in_ready = 0, out_valid = 0, out_insn = 0, out_addr = 0.
- busy = 0, done = 0, err = 0.
- Reset mid-session discards queued words and produces no done pulse.

## Timing

- A beat accepted at edge N is visible on out_insn/out_addr with out_valid at N+1 if the FIFO was empty at N.
- Throughput is one word per cycle while out_ready stays high.
- done asserts the cycle after the FIFO becomes empty in DRAIN. Minimum delay from the last beat's acceptance to done is 2 cycles, when the last word is popped immediately.
- err is a single-cycle pulse in the cycle after the offending beat is accepted.

## Configuration

Macro ITYPE_ENC_ILLEGAL_CHECK_EN.

- Defined: a shift beat (func3 001 or 101) with in_imm[11:5] ≠ 0 is accepted but dropped.
  - Nothing is pushed and the counter does not advance. err pulses.
  - A dropped beat carrying last still moves the FSM to DRAIN.
- Undefined: in_imm[11:5] is silently masked per the encoding rules, every beat is pushed, and err is tied to 0.

## Test plan

- Reset, then start with BASE_ADDR = 0x100. Send addi rd=1, rs1=2, imm=0xFFF with last = 1, out_ready held high.
  - Expect out_insn = 0xFFF10093 and out_addr = 0x100 one cycle after acceptance.
  - Expect done two cycles after acceptance, then busy = 0.
- Send srai rd=5, rs1=6, shamt=3 (in_arith = 1, in_imm = 0x003) → out_insn = 0x40335293. The same beat with in_arith = 0 → 0x00335293.
- Hold out_ready low and send 3 beats:
  - in_ready drops after 2 accepts.
  - Raising out_ready yields addresses 0x100, 0x104, 0x108 in order with no loss or duplication.
- With ITYPE_ENC_ILLEGAL_CHECK_EN defined, send slli with in_imm = 0x020 between two addi beats.
  - err pulses once.
  - Only 2 words are emitted, at consecutive addresses 0x100 and 0x104.
- With BASE_ADDR = 0xFFFFFFFC, send 2 beats → out_addr = 0xFFFFFFFC, then 0x00000000.
- Assert reset_n = 0 while 2 words are queued in RUN → next cycle out_valid = 0, in_ready = 0, busy = 0, and no done pulse.

Source files
------------

// File: rtl/itype_alu_encoder.sv
// Purpose : packs RV32I I-type ALU fields (addi..srai) into 32-bit words with sequential addresses.
// Latency : a beat accepted at edge N is presented at the FIFO head at N+1 when the FIFO was empty.
// Backpressure: 2-entry output FIFO; in_ready depends only on state and registered occupancy.
// Build option: define ITYPE_ENC_ILLEGAL_CHECK_EN to drop shift beats with in_imm[11:5] != 0 and pulse err.

module itype_alu_encoder #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_func3,
    input  logic              in_arith,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [11:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_insn,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [6:0]        OPCODE_OP_IMM = 7'b0010011;
    localparam logic [2:0]        F3_SLLI       = 3'b001;
    localparam logic [2:0]        F3_SRXI       = 3'b101;
    localparam logic [1:0]        FIFO_DEPTH    = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STEP     = ADDR_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Session state and address counter
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    // FIFO storage, pointers and occupancy
    logic [31:0]        insn_mem_q [2];
    logic [31:0]        insn_mem_d [2];
    logic [ADDR_W-1:0]  addr_mem_q [2];
    logic [ADDR_W-1:0]  addr_mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         cnt_q, cnt_d;

    // Registered status pulses
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Datapath intermediates
    logic [11:0]        imm12;
    logic [31:0]        enc_word;
    logic               is_shift;
    logic               drop;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;

    assign fifo_empty = (cnt_q == 2'd0);
    assign fifo_full  = (cnt_q == FIFO_DEPTH);

    // in_ready is a function of registered state only, so out_ready never reaches it combinationally
    assign in_ready  = (state_q == ST_RUN) && !fifo_full;
    assign out_valid = !fifo_empty;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = done_q;
    assign err       = err_q;

    // Head data is gated so an empty FIFO always presents zeros rather than stale words
    assign out_insn  = fifo_empty ? 32'd0      : insn_mem_q[rd_ptr_q];
    assign out_addr  = fifo_empty ? '0         : addr_mem_q[rd_ptr_q];

    // Encode the incoming beat and decide whether it is pushed or dropped
    always_comb begin
        imm12    = in_imm;
        is_shift = (in_func3 == F3_SLLI) || (in_func3 == F3_SRXI);
        drop     = 1'b0;

        // Shifts carry only a 5-bit shamt; bit 30 (imm12[10]) selects arithmetic right shift
        case (in_func3)
            F3_SLLI: imm12 = {7'b0000000, in_imm[4:0]};
            F3_SRXI: imm12 = {1'b0, in_arith, 5'b00000, in_imm[4:0]};
            default: imm12 = in_imm;
        endcase

`ifdef ITYPE_ENC_ILLEGAL_CHECK_EN
        // A shift with nonzero upper immediate bits is not a legal encoding: swallow it
        drop = is_shift && (in_imm[11:5] != 7'd0);
`else
        // Upper immediate bits of shifts are simply masked by the encoding above
        drop = 1'b0;
`endif

        enc_word = {imm12, in_rs1, in_func3, in_rd, OPCODE_OP_IMM};
        accept   = in_valid && in_ready;
        push     = accept && !drop;
        pop      = out_valid && out_ready;
    end

    // Session FSM, address counter and status pulses
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        err_d   = accept && drop;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = BASE_ADDR;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A dropped beat carrying last still closes the session
                if (accept && last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No pushes happen here, so registered occupancy is final
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter advances only for words actually queued; wraps naturally modulo 2^ADDR_W
        if (push) begin
            addr_d = addr_q + ADDR_STEP;
        end
    end

    // FIFO next-state: write at wr_ptr on push, advance rd_ptr on pop, occupancy tracks both
    always_comb begin
        insn_mem_d[0] = insn_mem_q[0];
        insn_mem_d[1] = insn_mem_q[1];
        addr_mem_d[0] = addr_mem_q[0];
        addr_mem_d[1] = addr_mem_q[1];
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;

        if (push) begin
            insn_mem_d[wr_ptr_q] = enc_word;
            addr_mem_d[wr_ptr_q] = addr_q;
            wr_ptr_d             = !wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end

        // Simultaneous push and pop leaves occupancy unchanged
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous active-low reset that overrides all other activity
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= BASE_ADDR;
            insn_mem_q[0] <= 32'd0;
            insn_mem_q[1] <= 32'd0;
            addr_mem_q[0] <= '0;
            addr_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            insn_mem_q[0] <= insn_mem_d[0];
            insn_mem_q[1] <= insn_mem_d[1];
            addr_mem_q[0] <= addr_mem_d[0];
            addr_mem_q[1] <= addr_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_itype_alu_encoder.sv
// Bench for itype_alu_encoder: two instances share stimulus, one based at 0x100 and one at 0xFFFFFFFC.
// Expected words come from a field-level encoding model and are queued on acceptance.
// A monitor pops and compares on every output handshake; done/err/in_ready are checked directly.

module tb_itype_alu_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        last;
    logic        in_valid;
    logic [2:0]  in_func3;
    logic        in_arith;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [11:0] in_imm;
    logic        out_ready;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] out_insn,  out_insn2;
    logic [31:0] out_addr,  out_addr2;
    logic        busy,      busy2;
    logic        done,      done2;
    logic        err,       err2;

    itype_alu_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0100)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .last(last),
        .in_valid(in_valid), .in_ready(in_ready), .in_func3(in_func3), .in_arith(in_arith),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_addr(out_addr),
        .busy(busy), .done(done), .err(err)
    );

    itype_alu_encoder #(.ADDR_W(32), .BASE_ADDR(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .start(start), .last(last),
        .in_valid(in_valid), .in_ready(in_ready2), .in_func3(in_func3), .in_arith(in_arith),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready), .out_insn(out_insn2), .out_addr(out_addr2),
        .busy(busy2), .done(done2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] off;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec        = 0;
    int          n_bad        = 0;
    int          done_cnt     = 0;
    int          sessions_exp = 0;
    logic [31:0] sess_off     = 32'd0;
    bit          rand_rdy     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word from the ISA field layout, using plain arithmetic
    function automatic logic [31:0] ref_encode(int f3, int arith, int rd, int rs1, int imm);
        longint imm12;
        longint w;
        logic [63:0] wv;
        if (f3 == 1)      imm12 = imm % 32;
        else if (f3 == 5) imm12 = (arith != 0 ? 1024 : 0) + imm % 32;
        else              imm12 = imm;
        w  = imm12 * 64'd1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19;
        wv = 64'(w);
        return wv[31:0];
    endfunction

    function automatic bit ref_dropped(int f3, int imm);
`ifdef ITYPE_ENC_ILLEGAL_CHECK_EN
        return ((f3 == 1) || (f3 == 5)) && ((imm / 32) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Advance one cycle; inputs change only 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        sess_off = 32'd0;
        sessions_exp++;
    endtask

    task automatic send_beat(input int f3, input int arith, input int rd, input int rs1,
                             input int imm, input bit is_last);
        bit   acc;
        bit   drp;
        exp_t e;
        acc = 1'b0;
        drp = ref_dropped(f3, imm);
        in_valid = 1'b1;
        in_func3 = 3'(f3);
        in_arith = arith[0];
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_imm   = 12'(imm);
        last     = is_last;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && !drp) begin
                e.insn = ref_encode(f3, arith, rd, rs1, imm);
                e.off  = sess_off;
                sbq.push_back(e);
                sess_off = sess_off + 32'd4;
            end
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        last     = 1'b0;
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: beat f3=%0d never accepted", f3);
        end else begin
            chk("err_pulse", {31'd0, err}, {31'd0, drp});
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: busy still 1 after 400 cycles");
        end
    endtask

    // Monitor: every handshake pops the scoreboard; every done pulse requires a drained queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_word: insn 0x%08h addr 0x%08h", out_insn, out_addr);
                end else begin
                    e = sbq.pop_front();
                    chk("out_insn",  out_insn,  e.insn);
                    chk("out_addr",  out_addr,  32'h0000_0100 + e.off);
                    chk("wrap_addr", out_addr2, 32'hFFFF_FFFC + e.off);
                    chk("wrap_valid", {31'd0, out_valid2}, 32'd1);
                end
            end
            if (reset_n && done) begin
                done_cnt++;
                chk("done_fifo_drained", sbq.size(), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int f3;
        int imm;
        reset_n   = 1'b0;
        start     = 1'b0;
        last      = 1'b0;
        in_valid  = 1'b0;
        in_func3  = 3'd0;
        in_arith  = 1'b0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_imm    = 12'd0;
        out_ready = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_insn",  out_insn,           32'd0);
        chk("rst_out_addr",  out_addr,           32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_err",       {31'd0, err},       32'd0);
        reset_n = 1'b1;
        tick();

        // Single addi with last: head at N+1, done at N+2
        out_ready = 1'b1;
        begin_session();
        send_beat(0, 0, 1, 2, 12'hFFF, 1'b1);
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_insn",  out_insn,           32'hFFF1_0093);
        chk("addi_addr",  out_addr,           32'h0000_0100);
        chk("addi_done0", {31'd0, done},      32'd0);
        tick();
        chk("addi_done1", {31'd0, done},      32'd0);
        chk("addi_busy1", {31'd0, busy},      32'd1);
        tick();
        chk("addi_done2", {31'd0, done},      32'd1);
        chk("addi_busy2", {31'd0, busy},      32'd0);
        tick();
        chk("addi_done3", {31'd0, done},      32'd0);

        // srai versus srli on the same fields
        begin_session();
        send_beat(5, 1, 5, 6, 12'h003, 1'b0);
        chk("srai_insn", out_insn, 32'h4033_5293);
        send_beat(5, 0, 5, 6, 12'h003, 1'b1);
        chk("srli_insn", out_insn, 32'h0033_5293);
        wait_idle();

        // Backpressure: FIFO full after two accepts, third beat waits
        out_ready = 1'b0;
        begin_session();
        send_beat(0, 0, 3, 4, 12'h001, 1'b0);
        send_beat(4, 0, 3, 4, 12'h002, 1'b0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        tick(); tick();
        chk("full_hold_ready", {31'd0, in_ready},  32'd0);
        chk("full_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("full_head_addr",  out_addr,           32'h0000_0100);
        out_ready = 1'b1;
        send_beat(6, 0, 3, 4, 12'h003, 1'b1);
        wait_idle();

        // Shift with upper immediate bits set between two addi beats
        begin_session();
        send_beat(0, 0, 7, 8, 12'h010, 1'b0);
        send_beat(1, 0, 7, 8, 12'h020, 1'b0);
        send_beat(0, 0, 7, 8, 12'h011, 1'b1);
        wait_idle();

        // Randomized sessions with random gaps and random out_ready
        rand_rdy = 1'b1;
        for (int s = 0; s < 30; s++) begin
            begin_session();
            nb = $urandom_range(1, 7);
            for (int b = 0; b < nb; b++) begin
                f3  = $urandom_range(0, 7);
                imm = $urandom_range(0, 4095);
                if ((f3 == 1 || f3 == 5) && ($urandom_range(0, 1) == 0)) imm = imm % 32;
                send_beat(f3, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
                          imm, b == nb - 1);
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            end
            wait_idle();
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        tick(); tick();

        // Reset mid-session with two words queued
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sess_off = 32'd0;
        send_beat(0, 0, 9, 10, 12'h055, 1'b0);
        send_beat(0, 0, 9, 10, 12'h056, 1'b0);
        chk("mid_valid_before", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        tick();
        sbq.delete();
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_in_ready",  {31'd0, in_ready},  32'd0);
        chk("mid_busy",      {31'd0, busy},      32'd0);
        chk("mid_done",      {31'd0, done},      32'd0);
        chk("mid_out_insn",  out_insn,           32'd0);
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("mid_no_done", {31'd0, done}, 32'd0);

        // Session accounting
        chk("done_count",  done_cnt,   sessions_exp);
        chk("sb_empty_end", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
